if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the fetch-buffer entries (legal range 2..4).
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, asynchronous and active-low.
REQ-005 SHALL have port redirect_i  input  1  meaning the taken branch/jump/jr redirect from a later stage.
REQ-006 SHALL have port redirect_pc_i  input  32  meaning the redirect target.
REQ-007 SHALL have port imem_req_o  output  1  meaning a one-cycle request pulse; memory always accepts it.
REQ-008 SHALL have port imem_addr_o  output  32  meaning the request address, valid while imem_req_o is high.
REQ-009 SHALL have port imem_rvalid_i  input  1  meaning the response is valid; at least 1 cycle after its request, in order.
REQ-010 SHALL have port imem_rdata_i  input  32  meaning the instruction word.
REQ-011 SHALL have port fetch_valid_o  output  1  meaning an instruction is offered to the IF/ID register.
REQ-012 SHALL have port fetch_ready_i  input  1  meaning IF/ID accepts this cycle (low = stall).
REQ-013 SHALL have port fetch_instr_o  output  32  meaning the offered instruction.
REQ-014 SHALL have port fetch_pc_incr_o  output  32  meaning the fetch address + 4 of the offered instruction.

Function
REQ-015 SHALL keep at most one memory request outstanding.
REQ-016 SHALL run FSM states RUN (no outstanding request), WAIT (request outstanding), and DROP (outstanding response to be discarded).
REQ-017 SHALL issue a request when in RUN, or in WAIT with imem_rvalid_i high, and the post-cycle buffer count is less than BUF_DEPTH.
REQ-018 SHALL move RUN->WAIT on issue, WAIT->RUN on rvalid without issue, WAIT->WAIT on rvalid with issue, and DROP->RUN on rvalid.
REQ-019 SHALL advance the fetch PC by 4 on each issue, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-020 SHALL push {imem_rdata_i, address+4} into the buffer on accepted rvalid; the output is registered, so fetch_valid_o rises the cycle after rvalid.
REQ-021 SHALL pop on fetch_valid_o & fetch_ready_i.
REQ-022 SHALL allow simultaneous push and pop in one cycle, with the count unchanged.
REQ-023 SHALL hold outputs stable while fetch_valid_o=1 and fetch_ready_i=0.
REQ-024 SHALL sustain 1 instr/cycle with 1-cycle memory latency and fetch_ready_i held high.
REQ-025 SHALL, on redirect_i, flush all buffer entries in the same edge and deassert fetch_valid_o next cycle.
REQ-026 SHALL, on redirect_i, load the fetch PC with {redirect_pc_i[31:2],2'b00}.
REQ-027 SHALL, on redirect_i, enter DROP if a request is outstanding and not returning this cycle, else RUN.
REQ-028 SHALL issue no request in the redirect cycle; the first request to the target is issued in the next cycle where RUN holds.
REQ-029 SHALL discard rvalid coincident with redirect_i.
REQ-030 SHALL complete a pop coincident with redirect_i as delivered; flushing it is the downstream's responsibility.
REQ-031 SHALL, in DROP, ignore fetch_ready_i for buffer purposes, the buffer being empty.
REQ-032 SHALL never overflow the buffer: full implies no issue; rvalid with a full buffer is impossible by REQ-017.

Reset
REQ-033 SHALL, while rst=0: state RUN, PC=RESET_PC, buffer empty, imem_req_o=0, fetch_valid_o=0, fetch_instr_o=0, fetch_pc_incr_o=0.
REQ-034 SHALL, on the first clock with rst=1, assert imem_req_o with imem_addr_o=RESET_PC.
REQ-035 SHALL, when reset asserts mid-request, forget the outstanding response; the memory model is reset concurrently.

Structure
REQ-036 SHALL declare the state encoding, instruction/address width constants and default RESET_PC in package mips_fetch_pkg.
REQ-037 SHALL place the buffer in sub-module fetch_fifo (parameter DEPTH; push/pop/flush; count output).

Verification
REQ-038 Reset release with 1-cycle memory and ready high -> requests at 0x0,0x4,0x8 on cycles 1,2,3, and fetch_valid_o from cycle 3 with pc_incr 0x4,0x8,0xC.
REQ-039 fetch_ready_i low for 5 cycles -> at most BUF_DEPTH entries buffered, no further requests, and outputs stable; on release the sequence continues without gap or duplicate.
REQ-040 3-cycle memory latency, redirect_i to 0x100 in the cycle after a request -> the returning word is dropped, the next request is 0x100, and the first delivered pc_incr is 0x104.
REQ-041 redirect_i to 0x203 coincident with rvalid -> the word is discarded, the request address is 0x200, and no stale instruction is delivered.
REQ-042 RESET_PC=32'hFFFF_FFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, with pc_incr wrapping the same way.
REQ-043 rst pulsed low while in WAIT -> all outputs are 0 immediately (async), and refetch from RESET_PC occurs after release.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package mips_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;

    // RUN: nothing outstanding, WAIT: request in flight, DROP: in-flight response is stale.
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetchState_e;

    // One buffered fetch result as presented to the IF/ID register.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pcIncr;
    } fetchEntry_t;

    // Force a target onto a word boundary.
    function automatic logic [ADDR_W-1:0] alignPc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer holding fetched instructions until IF/ID takes them.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] headData
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy tracking; flush empties the buffer in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Entry storage, written at the tail.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count gates every read, so stale contents are never observed.
        if (push && !flush) mem[wrPtr] <= pushData;
    end

    assign headData = mem[rdPtr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect handling, fetch buffer.
module if_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               fetch_valid_o,
    input  logic               fetch_ready_i,
    output logic [INSTR_W-1:0] fetch_instr_o,
    output logic [ADDR_W-1:0]  fetch_pc_incr_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetchState_e       state;
    fetchState_e       stateNext;
    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] fetchPcNext;
    logic              doIssue;
    logic              doPush;
    logic              doPop;
    logic [CNT_W-1:0]  bufCount;
    logic [CNT_W-1:0]  postCount;
    fetchEntry_t       pushEntry;
    fetchEntry_t       headEntry;

    // A response is kept only when it belongs to the live request stream.
    assign doPush = (state == S_WAIT) && imem_rvalid_i && !redirect_i;
    assign doPop  = fetch_valid_o && fetch_ready_i;

    // While in WAIT the fetch PC already points one word past the outstanding
    // request, which is exactly the pc+4 that travels with the returning word.
    assign pushEntry = '{instr: imem_rdata_i, pcIncr: fetchPc};

    // Next-state, issue decision and fetch PC update.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        stateNext   = state;
        fetchPcNext = fetchPc;
        doIssue     = 1'b0;
        postCount   = bufCount + CNT_W'(doPush) - CNT_W'(doPop);

        if (redirect_i) begin
            // A request still in flight must have its response swallowed.
            stateNext   = (state != S_RUN && !imem_rvalid_i) ? S_DROP : S_RUN;
            fetchPcNext = alignPc(redirect_pc_i);
        end else begin
            // Issuing only when the buffer will still have room guarantees the
            // response always finds a free slot. rst keeps the pulse low in reset.
            doIssue = rst && (postCount < CNT_W'(BUF_DEPTH)) &&
                      ((state == S_RUN) || (state == S_WAIT && imem_rvalid_i));
            case (state)
                S_RUN:   if (doIssue) stateNext = S_WAIT;
                S_WAIT:  if (imem_rvalid_i) stateNext = doIssue ? S_WAIT : S_RUN;
                S_DROP:  if (imem_rvalid_i) stateNext = S_RUN;
                default: stateNext = S_RUN;
            endcase
            if (doIssue) fetchPcNext = fetchPc + PC_STEP;
        end
    end

    // FSM state and fetch PC registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_RUN;
            fetchPc <= RESET_PC;
        end else begin
            state   <= stateNext;
            fetchPc <= fetchPcNext;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetchEntry_t))
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (doPush),
        .pushData (pushEntry),
        .pop      (doPop),
        .flush    (redirect_i),
        .count    (bufCount),
        .headData (headEntry)
    );

    assign imem_req_o      = doIssue;
    assign imem_addr_o     = doIssue ? fetchPc : '0;
    assign fetch_valid_o   = (bufCount != '0);
    assign fetch_instr_o   = fetch_valid_o ? headEntry.instr  : '0;
    assign fetch_pc_incr_o = fetch_valid_o ? headEntry.pcIncr : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural instruction memory.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        ready;
    logic        rvalid = 1'b0;
    logic [31:0] rdata  = 32'h0;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcIncr;

    logic        rvalid2 = 1'b0;
    logic [31:0] rdata2  = 32'h0;
    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pcIncr2;

    int          checks = 0;
    int          errors = 0;
    int          memLat = 1;
    logic        reqFire  = 1'b0;
    logic        reqFire2 = 1'b0;
    logic [31:0] reqAddr  = 32'h0;
    logic [31:0] reqAddr2 = 32'h0;
    logic        pending  = 1'b0;
    logic [31:0] pendAddr = 32'h0;
    int          remaining = 0;
    logic        found;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .redirect_i(redirect), .redirect_pc_i(redirectPc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .fetch_valid_o(valid), .fetch_ready_i(ready), .fetch_instr_o(instr),
        .fetch_pc_incr_o(pcIncr)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dutWrap (
        .clk(clk), .rst(rst), .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_rvalid_i(rvalid2), .imem_rdata_i(rdata2),
        .fetch_valid_o(valid2), .fetch_ready_i(1'b1), .fetch_instr_o(instr2),
        .fetch_pc_incr_o(pcIncr2)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Capture the request presented in the cycle that ends at this edge.
    always @(posedge clk) begin
        reqFire  = req;
        reqAddr  = addr;
        reqFire2 = req2;
        reqAddr2 = addr2;
    end

    // Main memory: in-order, one outstanding request, programmable latency.
    always @(negedge clk) begin
        rvalid = 1'b0;
        rdata  = 32'h0;
        if (!rst) begin
            pending = 1'b0;
        end else begin
            if (reqFire) begin
                pending   = 1'b1;
                pendAddr  = reqAddr;
                remaining = memLat - 1;
            end else if (pending && remaining > 0) begin
                remaining = remaining - 1;
            end
            if (pending && remaining == 0) begin
                rvalid  = 1'b1;
                rdata   = memWord(pendAddr);
                pending = 1'b0;
            end
        end
    end

    // Memory for the wrapped-PC instance: fixed one-cycle latency.
    always @(negedge clk) begin
        rvalid2 = rst && reqFire2;
        rdata2  = memWord(reqAddr2);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bounded wait: sel 0 = fetch_valid_o, sel 1 = imem_rvalid_i.
    task automatic waitFor(input int sel, input int budget, output logic hit);
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 && valid) || (sel == 1 && rvalid)) begin
                hit = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirectPc = 32'h0; ready = 1'b1;
        repeat (3) step();
        check("rst_req",    req,    32'h0);
        check("rst_addr",   addr,   32'h0);
        check("rst_valid",  valid,  32'h0);
        check("rst_instr",  instr,  32'h0);
        check("rst_pcincr", pcIncr, 32'h0);

        // Reset release, one-cycle memory, ready high.
        rst = 1'b1; #1;
        check("c1_req",   req,   32'h1);
        check("c1_addr",  addr,  32'h0);
        check("w_c1_addr", addr2, 32'hFFFF_FFF8);
        step();
        check("c2_req",   req,   32'h1);
        check("c2_addr",  addr,  32'h4);
        check("c2_valid", valid, 32'h0);
        check("w_c2_addr", addr2, 32'hFFFF_FFFC);
        step();
        check("c3_addr",   addr,   32'h8);
        check("c3_valid",  valid,  32'h1);
        check("c3_pcincr", pcIncr, 32'h4);
        check("c3_instr",  instr,  memWord(32'h0));
        check("w_c3_addr",   addr2,   32'h0);
        check("w_c3_pcincr", pcIncr2, 32'hFFFF_FFFC);
        step();
        check("c4_pcincr", pcIncr, 32'h8);
        check("w_c4_pcincr", pcIncr2, 32'h0);
        check("w_c4_instr",  instr2,  memWord(32'hFFFF_FFFC));
        step();
        check("c5_pcincr", pcIncr, 32'hC);
        check("w_c5_pcincr", pcIncr2, 32'h4);

        // Stall for five cycles: buffer fills, requests stop, head holds.
        step(); ready = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",  valid,  32'h1);
            check("stall_pcincr", pcIncr, 32'h10);
            check("stall_instr",  instr,  memWord(32'hC));
            check("stall_req",    req,    32'h0);
            if (i < 4) step();
        end
        step(); ready = 1'b1; #1;
        check("rel_pcincr0", pcIncr, 32'h10);
        check("rel_req",     req,    32'h1);
        check("rel_addr0",   addr,   32'h14);
        step();
        check("rel_pcincr1", pcIncr, 32'h14);
        check("rel_addr1",   addr,   32'h18);
        step();
        check("rel_pcincr2", pcIncr, 32'h18);
        check("rel_addr2",   addr,   32'h1C);
        memLat = 3;

        // Redirect one cycle after a slow request: its response must be dropped.
        step();
        check("pre_redir_pcincr", pcIncr, 32'h1C);
        redirect = 1'b1; redirectPc = 32'h100; #1;
        check("redir_req", req, 32'h0);
        step(); redirect = 1'b0; #1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req) begin
                found = 1'b1;
                break;
            end
            check("drop_quiet", valid, 32'h0);
            step();
        end
        check("drop_req_seen", found, 32'h1);
        check("drop_req_addr", addr,  32'h100);
        waitFor(0, 10, found);
        check("drop_valid_seen", found,  32'h1);
        check("drop_pcincr",     pcIncr, 32'h104);
        check("drop_instr",      instr,  memWord(32'h100));

        // Redirect to an unaligned target coincident with a response.
        waitFor(1, 10, found);
        check("coinc_rvalid_seen", found, 32'h1);
        redirect = 1'b1; redirectPc = 32'h203; #1;
        check("coinc_req", req, 32'h0);
        step(); redirect = 1'b0; #1;
        check("coinc_next_req",   req,   32'h1);
        check("coinc_next_addr",  addr,  32'h200);
        check("coinc_next_valid", valid, 32'h0);
        waitFor(0, 10, found);
        check("coinc_valid_seen", found,  32'h1);
        check("coinc_pcincr",     pcIncr, 32'h204);
        check("coinc_instr",      instr,  memWord(32'h200));

        // Asynchronous reset while a request is in flight.
        #2; rst = 1'b0; #1;
        check("arst_req",    req,    32'h0);
        check("arst_addr",   addr,   32'h0);
        check("arst_valid",  valid,  32'h0);
        check("arst_instr",  instr,  32'h0);
        check("arst_pcincr", pcIncr, 32'h0);
        step();
        step();
        memLat = 1;
        rst = 1'b1; #1;
        check("rf_req",     req,   32'h1);
        check("rf_addr",    addr,  32'h0);
        check("w_rf_addr",  addr2, 32'hFFFF_FFF8);
        step();
        check("rf_addr1",   addr,  32'h4);
        step();
        check("rf_valid",   valid,  32'h1);
        check("rf_pcincr",  pcIncr, 32'h4);
        check("rf_instr",   instr,  memWord(32'h0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
